// File: rtl/neo_rx_pkg.sv
// -----------------------------------------------------------------------------
// neo_rx_pkg
// Shared definitions for the single-wire pixel link (receive and transmit side).
// Holds the receiver state enum and the default pulse timing constants, all
// expressed in clk cycles at 100 MHz.
// -----------------------------------------------------------------------------
package neo_rx_pkg;

    // Receiver decode states
    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } neo_state_e;

    // High-pulse length (cycles) at or above which a bit reads as 1
    localparam int NEO_T_BIT_THRESH = 45;
    // High-pulse length (cycles) above which the pulse is a framing error
    localparam int NEO_T_MAX_HIGH   = 100;
    // Continuous low length (cycles) that terminates a frame (80 us)
    localparam int NEO_T_RESET      = 8000;
    // Maximum number of 32-bit words accepted per frame
    localparam int NEO_PIX_MAX      = 30;

endpackage

// File: rtl/neo_pulse_meas.sv
// -----------------------------------------------------------------------------
// neo_pulse_meas
// Front end of the pixel receiver: brings the asynchronous line into the clk
// domain, flags its edges and measures the length of the current high and low
// run with counters that saturate instead of wrapping.
//
// Ports
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   din_i       : raw asynchronous line
//   ds_o        : synchronized line (two flops behind din_i)
//   rise_o      : ds_o went 0->1 this cycle
//   fall_o      : ds_o went 1->0 this cycle
//   high_cnt_o  : number of consecutive high cycles before this one
//   low_cnt_o   : number of consecutive low cycles before this one
// -----------------------------------------------------------------------------
module neo_pulse_meas
    import neo_rx_pkg::*;
#(
    parameter int T_RESET = NEO_T_RESET,
    parameter int CNT_W   = $clog2(T_RESET + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             din_i,
    output logic             ds_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W-1:0] low_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(T_RESET);

    logic [1:0]       sync_q;
    logic             dsPrev_q;
    logic [CNT_W-1:0] highCnt_q, highCnt_d;
    logic [CNT_W-1:0] lowCnt_q, lowCnt_d;
    logic             ds;

    assign ds = sync_q[1];

    // Each run counter restarts whenever the line leaves its level, so in the
    // cycle an edge is seen the opposite counter still holds the full length
    // of the run that just ended.
    always_comb begin
        highCnt_d = '0;
        lowCnt_d  = '0;
        if (ds) begin
            highCnt_d = (highCnt_q == CNT_MAX) ? CNT_MAX : highCnt_q + CNT_W'(1);
        end else begin
            lowCnt_d  = (lowCnt_q == CNT_MAX) ? CNT_MAX : lowCnt_q + CNT_W'(1);
        end
    end

    // Two-flop synchronizer, previous-sample flop for edge detection and the
    // run counters all live here so the decoder only sees clean timing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            dsPrev_q  <= 1'b0;
            highCnt_q <= '0;
            lowCnt_q  <= '0;
        end else begin
            sync_q    <= {sync_q[0], din_i};
            dsPrev_q  <= ds;
            highCnt_q <= highCnt_d;
            lowCnt_q  <= lowCnt_d;
        end
    end

    assign ds_o       = ds;
    assign rise_o     = ds & ~dsPrev_q;
    assign fall_o     = ~ds & dsPrev_q;
    assign high_cnt_o = highCnt_q;
    assign low_cnt_o  = lowCnt_q;

endmodule

// File: rtl/neo_rx.sv
// -----------------------------------------------------------------------------
// neo_rx
// Single-wire pixel stream receiver. Decodes pulse-width coded bits MSB-first
// into 32-bit words, frames them with a long low gap, and forwards the rest of
// the stream to the next pixel once its own first word has been taken.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   din        : asynchronous pixel stream in
//   word_out   : last decoded word, first received bit at bit 31
//   word_valid : one-cycle pulse, word_out is new
//   word_index : position of word_out within the frame, from 0
//   frame_done : one-cycle pulse at a clean frame end
//   err        : one-cycle pulse on a framing error
//   dout       : forwarded stream for the downstream pixel
// -----------------------------------------------------------------------------
module neo_rx
    import neo_rx_pkg::*;
#(
    parameter int T_BIT_THRESH = NEO_T_BIT_THRESH,
    parameter int T_MAX_HIGH   = NEO_T_MAX_HIGH,
    parameter int T_RESET      = NEO_T_RESET,
    parameter int PIX_MAX      = NEO_PIX_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic [4:0]  word_index,
    output logic        frame_done,
    output logic        err,
    output logic        dout
);

    localparam int CNT_W  = $clog2(T_RESET + 1);
    localparam int WCNT_W = $clog2(PIX_MAX + 1);

    logic             ds, rise, fall;
    logic [CNT_W-1:0] highCnt, lowCnt;

    neo_pulse_meas #(
        .T_RESET (T_RESET),
        .CNT_W   (CNT_W)
    ) u_meas (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .din_i      (din),
        .ds_o       (ds),
        .rise_o     (rise),
        .fall_o     (fall),
        .high_cnt_o (highCnt),
        .low_cnt_o  (lowCnt)
    );

    neo_state_e        state_q, state_d;
    logic [30:0]       shift_q;
    logic [4:0]        bitCnt_q;
    logic [WCNT_W-1:0] wordCnt_q;
    logic              ovf_q;
    logic              fwd_q;
    logic [31:0]       wordOut_q;
    logic              wordValid_q;
    logic [4:0]        wordIndex_q;
    logic              frameDone_q;
    logic              err_q;

    logic        lowDone, tooLong, newBit;
    logic        bitStrobe, pulseErr, frameEnd;
    logic        wordDone, wordAccepted, overflowHit;
    logic [31:0] shiftNext;

    // lowDone marks the cycle in which the line has been low for the full
    // reset length, counting the current cycle.
    assign lowDone = ~ds && (lowCnt >= CNT_W'(T_RESET - 1));
    assign tooLong = highCnt > CNT_W'(T_MAX_HIGH);
    assign newBit  = highCnt >= CNT_W'(T_BIT_THRESH);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. An over-long pulse is caught even in the cycle it
    // ends, so it takes priority over the falling edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: if (lowDone) state_d = ST_IDLE;
            ST_IDLE: if (rise) state_d = ST_HIGH;
            ST_HIGH: begin
                if (tooLong) begin
                    state_d = ST_SYNC;
                end else if (fall) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (lowDone) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // Control strobes decoded from the state and the measured line timing
    always_comb begin
        bitStrobe = 1'b0;
        pulseErr  = 1'b0;
        frameEnd  = 1'b0;
        case (state_q)
            ST_HIGH: begin
                pulseErr  = tooLong;
                bitStrobe = ~tooLong & fall;
            end
            ST_LOW:  frameEnd = lowDone;
            default: ;
        endcase
    end

    assign shiftNext    = {shift_q, newBit};
    assign wordDone     = bitStrobe && (bitCnt_q == 5'd31);
    assign wordAccepted = wordDone && (wordCnt_q < WCNT_W'(PIX_MAX));
    assign overflowHit  = wordDone && !wordAccepted && !ovf_q;

    // Shifter, word/frame bookkeeping and forwarding enable. Words beyond the
    // frame limit are still shifted so a following partial word is detected,
    // but only the first excess word raises err. Forwarding starts when word 0
    // completes, which is always on a falling edge so the line is already low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            bitCnt_q    <= '0;
            wordCnt_q   <= '0;
            ovf_q       <= 1'b0;
            fwd_q       <= 1'b0;
            wordOut_q   <= '0;
            wordValid_q <= 1'b0;
            wordIndex_q <= '0;
            frameDone_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wordValid_q <= 1'b0;
            frameDone_q <= 1'b0;
            err_q       <= 1'b0;
            if (bitStrobe) begin
                shift_q  <= shiftNext[30:0];
                bitCnt_q <= bitCnt_q + 5'd1;
            end
            if (wordAccepted) begin
                wordOut_q   <= shiftNext;
                wordValid_q <= 1'b1;
                wordIndex_q <= 5'(wordCnt_q);
                wordCnt_q   <= wordCnt_q + WCNT_W'(1);
                if (wordCnt_q == '0) begin
                    fwd_q <= 1'b1;
                end
            end
            if (overflowHit) begin
                err_q       <= 1'b1;
                ovf_q       <= 1'b1;
                fwd_q       <= 1'b0;
                wordIndex_q <= '0;
            end
            if (frameEnd || pulseErr) begin
                if (frameEnd && bitCnt_q == '0) begin
                    frameDone_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
                shift_q     <= '0;
                bitCnt_q    <= '0;
                wordCnt_q   <= '0;
                ovf_q       <= 1'b0;
                fwd_q       <= 1'b0;
                wordIndex_q <= '0;
            end
        end
    end

    assign word_out   = wordOut_q;
    assign word_valid = wordValid_q;
    assign word_index = wordIndex_q;
    assign frame_done = frameDone_q;
    assign err        = err_q;
    assign dout       = fwd_q & ds;

endmodule

// File: tb/tb_neo_rx.sv
// -----------------------------------------------------------------------------
// tb_neo_rx
// Self-checking bench for neo_rx. The DUT runs with scaled-down timing so whole
// frames fit in a short run; bit widths, word limits and all rules are the same.
// Stimulus words and pulse timings are random; expectations come from the
// transmitted word list and the frame rules, and dout is checked against din
// delayed by two cycles once word 0 of the frame has been sent.
// -----------------------------------------------------------------------------
module tb_neo_rx;

    localparam int TB_THRESH = 12;
    localparam int TB_MAXH   = 30;
    localparam int TB_RESET  = 400;
    localparam int TB_PIX    = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic [31:0] word_out;
    logic        word_valid;
    logic [4:0]  word_index;
    logic        frame_done;
    logic        err;
    logic        dout;

    neo_rx #(
        .T_BIT_THRESH (TB_THRESH),
        .T_MAX_HIGH   (TB_MAXH),
        .T_RESET      (TB_RESET),
        .PIX_MAX      (TB_PIX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_index (word_index),
        .frame_done (frame_done),
        .err        (err),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] txWords[$];
    logic [31:0] gotWords[$];
    logic [4:0]  gotIdx[$];
    int          fdCnt, errCnt, bothCnt, doutErr, doutHigh;
    logic        fwdModel, monDout, fixedTiming;
    logic        dinH1, dinH2, fwdH1, fwdH2;

    // Single comparison point: counts and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Event monitor sampling on the falling clock edge
    initial begin
        dinH1 = 1'b0; dinH2 = 1'b0; fwdH1 = 1'b0; fwdH2 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (word_valid) begin
                    gotWords.push_back(word_out);
                    gotIdx.push_back(word_index);
                end
                if (frame_done) fdCnt++;
                if (err) errCnt++;
                if (word_valid && frame_done) bothCnt++;
                if (monDout) begin
                    if (dout !== (fwdH2 & dinH2)) doutErr++;
                    if (dout === 1'b1) doutHigh++;
                end
            end
            dinH2 = dinH1; dinH1 = din;
            fwdH2 = fwdH1; fwdH1 = fwdModel;
        end
    end

    // Safety net so the run always ends
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearMonitor();
        gotWords.delete();
        gotIdx.delete();
        fdCnt = 0; errCnt = 0; bothCnt = 0; doutErr = 0; doutHigh = 0;
    endtask

    task automatic holdDin(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One pulse-width coded bit; markFwd flags the end of word 0's last high
    task automatic sendBit(input logic v, input logic markFwd);
        int h, l;
        if (fixedTiming) begin
            h = v ? 16 : 8;
            l = v ? 16 : 24;
        end else begin
            h = v ? int'($urandom_range(TB_MAXH, TB_THRESH)) : int'($urandom_range(TB_THRESH - 1, 2));
            l = int'($urandom_range(20, 4));
        end
        holdDin(1'b1, h);
        if (markFwd) fwdModel = 1'b1;
        holdDin(1'b0, l);
    endtask

    task automatic sendWord(input logic [31:0] w, input logic first);
        for (int b = 31; b >= 0; b--) begin
            sendBit(w[b], first && (b == 0));
        end
    endtask

    // Sends txWords as one frame plus extraBits loose bits, then the reset gap
    task automatic applyStimulus(input int extraBits);
        for (int i = 0; i < txWords.size(); i++) begin
            sendWord(txWords[i], i == 0);
        end
        for (int i = 0; i < extraBits; i++) begin
            sendBit(1'($urandom_range(1, 0)), 1'b0);
        end
        fwdModel = 1'b0;
        holdDin(1'b0, TB_RESET + 20);
    endtask

    task automatic checkFrame(input string tag, input int extraBits);
        int nExp;
        int expErr;
        nExp   = (txWords.size() > TB_PIX) ? TB_PIX : txWords.size();
        expErr = ((txWords.size() > TB_PIX) ? 1 : 0) + (((extraBits % 32) != 0) ? 1 : 0);
        checkOutput({tag, "_nvalid"}, gotWords.size(), nExp);
        for (int i = 0; i < nExp && i < gotWords.size(); i++) begin
            checkOutput($sformatf("%s_word%0d", tag, i), gotWords[i], txWords[i]);
            checkOutput($sformatf("%s_idx%0d", tag, i), 32'(gotIdx[i]), 32'(i));
        end
        checkOutput({tag, "_frame_done"}, fdCnt, ((extraBits % 32) == 0) ? 1 : 0);
        checkOutput({tag, "_err"}, errCnt, expErr);
        checkOutput({tag, "_valid_and_done"}, bothCnt, 0);
        if (monDout) begin
            checkOutput({tag, "_dout_follow"}, doutErr, 0);
            checkOutput({tag, "_dout_active"}, 32'(doutHigh > 0), 32'(txWords.size() > 1));
        end
    endtask

    task automatic runFrame(input string tag, input int extraBits, input logic mon);
        clearMonitor();
        monDout = mon;
        applyStimulus(extraBits);
        checkFrame(tag, extraBits);
        monDout = 1'b0;
    endtask

    task automatic randomWords(input int n);
        txWords.delete();
        for (int i = 0; i < n; i++) txWords.push_back($urandom());
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_word_out"}, word_out, 32'h0);
        checkOutput({tag, "_word_valid"}, 32'(word_valid), 32'h0);
        checkOutput({tag, "_word_index"}, 32'(word_index), 32'h0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        checkOutput({tag, "_err"}, 32'(err), 32'h0);
        checkOutput({tag, "_dout"}, 32'(dout), 32'h0);
    endtask

    initial begin
        din = 1'b0; rst_n = 1'b0;
        fwdModel = 1'b0; monDout = 1'b0; fixedTiming = 1'b0;
        clearMonitor();
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        holdDin(1'b0, TB_RESET + 20);

        // Fixed-timing single word
        fixedTiming = 1'b1;
        txWords = '{32'hFF000500};
        runFrame("single", 0, 1'b1);
        fixedTiming = 1'b0;

        // Three known words, random timing, forwarding checked
        txWords = '{32'h00FF0000, 32'h12345678, 32'hFFFFFFFF};
        runFrame("three", 0, 1'b1);

        // Random frames
        for (int f = 0; f < 3; f++) begin
            randomWords(int'($urandom_range(4, 1)));
            runFrame($sformatf("rand%0d", f), 0, 1'b1);
        end

        // Over-long high pulse mid-word, then a word sent before a full gap
        clearMonitor();
        for (int i = 0; i < 5; i++) sendBit(1'($urandom_range(1, 0)), 1'b0);
        holdDin(1'b1, TB_MAXH + 1);
        holdDin(1'b0, 50);
        sendWord($urandom(), 1'b0);
        holdDin(1'b0, TB_RESET + 20);
        checkOutput("long_err", errCnt, 1);
        checkOutput("long_nvalid", gotWords.size(), 0);
        checkOutput("long_frame_done", fdCnt, 0);
        randomWords(1);
        runFrame("after_long", 0, 1'b1);

        // 40 bits: one word then a partial word, next frame must start clean
        randomWords(1);
        runFrame("partial", 8, 1'b0);
        randomWords(1);
        runFrame("after_partial", 0, 1'b1);

        // One word more than the frame limit
        randomWords(TB_PIX + 1);
        runFrame("overflow", 0, 1'b0);

        // Reset during bit 17, then a word sent after too short a low period
        clearMonitor();
        randomWords(1);
        for (int b = 31; b > 15; b--) sendBit(txWords[0][b], 1'b0);
        holdDin(1'b1, 5);
        rst_n = 1'b0;
        #2;
        checkAllZero("midreset");
        repeat (3) @(posedge clk);
        #1;
        din = 1'b0;
        rst_n = 1'b1;
        holdDin(1'b0, 100);
        sendWord($urandom(), 1'b0);
        holdDin(1'b0, TB_RESET + 20);
        checkOutput("midreset_nvalid", gotWords.size(), 0);
        checkOutput("midreset_err", errCnt, 0);
        randomWords(2);
        runFrame("after_reset", 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neo_rx.md
NEO_RX -- requirements
Module: neo_rx

Interface
REQ-001 SHALL have parameter T_BIT_THRESH, default 45, meaning a high-pulse length in clk cycles at or above which the bit decodes as 1.
REQ-002 SHALL have parameter T_MAX_HIGH, default 100, meaning the high-pulse length in clk cycles above which the pulse is a framing error.
REQ-003 SHALL have parameter T_RESET, default 8000, meaning the continuous-low length in clk cycles that ends a frame (80 us at 100 MHz).
REQ-004 SHALL have parameter PIX_MAX, default 30, meaning the maximum number of 32-bit words per frame.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port din, input, 1 bit: the asynchronous single-wire pixel stream.
REQ-008 SHALL have port word_out, output, 32 bits: the last decoded word, first-received bit at bit 31.
REQ-009 SHALL have port word_valid, output, 1 bit: a one-cycle pulse marking word_out as new.
REQ-010 SHALL have port word_index, output, 5 bits: the position of word_out in the current frame, starting at 0.
REQ-011 SHALL have port frame_done, output, 1 bit: a one-cycle pulse at the end of a frame.
REQ-012 SHALL have port err, output, 1 bit: a one-cycle pulse on a framing error.
REQ-013 SHALL have port dout, output, 1 bit: the forwarded stream for the downstream pixel chain.

Function
REQ-014 SHALL pass din through a two-flop synchronizer; all timing below refers to the synchronized signal (ds).
REQ-015 SHALL implement the states SYNC, IDLE, HIGH and LOW.
REQ-016 SYNC: SHALL count consecutive low cycles; on reaching T_RESET, SHALL go to IDLE; any high SHALL clear the count.
REQ-017 IDLE: on the rising edge of ds, SHALL clear the pulse counter and go to HIGH.
REQ-018 HIGH: SHALL count high cycles; if the count exceeds T_MAX_HIGH, SHALL pulse err and go to SYNC.
REQ-019 HIGH, on the falling edge of ds: SHALL shift in bit = (count >= T_BIT_THRESH) and go to LOW.
REQ-020 LOW: on the rising edge of ds, SHALL go to HIGH.
REQ-021 LOW: on reaching T_RESET low cycles, SHALL end the frame and go to IDLE.
REQ-022 Frame end with a bit count of 0 mod 32: SHALL pulse frame_done.
REQ-023 Frame end with a nonzero partial word: SHALL pulse err instead of frame_done, and SHALL discard the partial word.
REQ-024 Bit shift SHALL be MSB-first into a 32-bit register.
REQ-025 After the 32nd bit: SHALL load word_out and pulse word_valid in the cycle after that falling edge is detected.
REQ-026 word_index SHALL increment after each word and clear at frame end or error.
REQ-027 Words arriving after PIX_MAX in a frame: SHALL not assert word_valid and SHALL pulse err once; decoding SHALL continue to frame end.
REQ-028 dout SHALL be 0 until word 0 of the frame completes and ds is low.
REQ-029 After that point, dout SHALL equal ds (two-cycle latency from din) until frame end or error.
REQ-030 Counters SHALL saturate at T_RESET and never wrap; counter width SHALL be clog2(T_RESET+1).
REQ-031 word_valid and frame_done SHALL never be asserted in the same cycle.
REQ-032 word_out SHALL hold its value between word_valid pulses.

Reset
REQ-033 rst_n low SHALL asynchronously force: state=SYNC, word_out=0, word_valid=0, word_index=0, frame_done=0, err=0, dout=0, synchronizer=0, all counters=0.
REQ-034 Reset asserted mid-frame SHALL discard all partial data; after release, the block SHALL require a full T_RESET low period before decoding.

Structure
REQ-035 A shared package SHALL hold the state enum and the default timing constants, shared with the transmit side.
REQ-036 One sub-module, neo_pulse_meas (synchronizer, edge detect, saturating high/low counters), SHALL be instantiated; the FSM, shifter and forwarding logic SHALL live in neo_rx.

Verification
REQ-037 Stimulus: low 8000 cycles, then one 32-bit word 0xFF000500 (1: 60 high/60 low, 0: 30 high/90 low), then low 8000 cycles. Response: one word_valid with word_out=0xFF000500 and word_index=0, then frame_done, err=0.
REQ-038 Stimulus: a frame of 3 words 0x00FF0000, 0x12345678, 0xFFFFFFFF. Response: three word_valid pulses with indices 0,1,2 and correct values; dout toggles only during words 1-2, with a 2-cycle lag.
REQ-039 Stimulus: a high pulse of 150 cycles mid-word. Response: one err pulse, no word_valid, and no decode until 8000 low cycles have elapsed.
REQ-040 Stimulus: 40 bits then a reset gap. Response: one word_valid for the first 32 bits, then an err pulse instead of frame_done.
REQ-041 Stimulus: 31 words. Response: 30 word_valid pulses and one err pulse.
REQ-042 Stimulus: rst_n low for 3 cycles during bit 17 of a word. Response: all outputs 0 immediately, and the next word decodes only after a full 8000-cycle low period.
